// File: rtl/wave_scorer_if.sv
// Score/clear tracker bus: kill and game events in, per-wave score and status out.
// The master side is the collision/alien-grid logic plus score display; the slave side is wave_scorer.
interface wave_scorer_if;
  logic        start;
  logic        kill;
  logic [2:0]  kill_row;
  logic        ufo_kill;
  logic        player_dead;
  logic [10:0] wave_score;
  logic        win;
  logic        lose;
  logic [5:0]  aliens_left;
  logic [7:0]  wave_num;

  modport master (
    output start, kill, kill_row, ufo_kill, player_dead,
    input  wave_score, win, lose, aliens_left, wave_num
  );

  modport slave (
    input  start, kill, kill_row, ufo_kill, player_dead,
    output wave_score, win, lose, aliens_left, wave_num
  );
endinterface

// File: rtl/wave_scorer.sv
// Per-wave score and clear tracker.
// Accumulates kill points for the current wave, counts remaining aliens, pulses win
// for one cycle when the wave is cleared and holds lose once the player dies.
// Optional feature macro: UFO_BONUS_EN (one UFO bonus accepted per wave).
//
// state | meaning
// IDLE  | between waves; score reads 0, waits for start
// PLAY  | wave in progress; kills scored and counted
// WIN   | one cycle; win=1 with the final wave total on wave_score
// LOST  | game over; lose=1, everything frozen until reset
module wave_scorer #(
  parameter int NUM_ALIENS = 55,
  parameter int PTS_TOP    = 30,
  parameter int PTS_MID    = 20,
  parameter int PTS_BOT    = 10,
  parameter int UFO_POINTS = 110
) (
  input  logic           clk,
  input  logic           reset,
  wave_scorer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, PLAY, WIN, LOST} state_t;

  localparam logic [5:0]  NUM_ALIENS_C = 6'(NUM_ALIENS);
  localparam logic [10:0] PTS_TOP_C    = 11'(PTS_TOP);
  localparam logic [10:0] PTS_MID_C    = 11'(PTS_MID);
  localparam logic [10:0] PTS_BOT_C    = 11'(PTS_BOT);
  localparam logic [10:0] UFO_PTS_C    = 11'(UFO_POINTS);
  localparam logic [11:0] SCORE_MAX    = 12'd2047;

  state_t      state, state_n;
  logic [10:0] score_q, score_n;
  logic [5:0]  aliens_q, aliens_n;
  logic [7:0]  wave_q, wave_n;
  logic        ufo_q, ufo_n;

  logic        kill_ok;
  logic [10:0] kill_pts;
  logic [10:0] ufo_add;
  logic        ufo_ok;
  logic [11:0] score_sum;

  // Row-to-points lookup; rows 5..7 are not real rows and score nothing.
  always_comb begin
    kill_pts = '0;
    case (bus.kill_row)
      3'd0:       kill_pts = PTS_TOP_C;
      3'd1, 3'd2: kill_pts = PTS_MID_C;
      3'd3, 3'd4: kill_pts = PTS_BOT_C;
      default:    kill_pts = '0;
    endcase
  end

  assign kill_ok = bus.kill && (bus.kill_row <= 3'd4) && (aliens_q != 6'd0);

`ifdef UFO_BONUS_EN
  assign ufo_ok  = bus.ufo_kill && !ufo_q;
  assign ufo_add = ufo_ok ? UFO_PTS_C : 11'd0;
`else
  // UFO events carry no weight in this build.
  logic unused_ufo;
  assign unused_ufo = ^{bus.ufo_kill, ufo_q, UFO_PTS_C};
  assign ufo_ok  = 1'b0;
  assign ufo_add = 11'd0;
`endif

  assign score_sum = {1'b0, score_q} + {1'b0, (kill_ok ? kill_pts : 11'd0)} + {1'b0, ufo_add};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and next-datapath decode.
  always_comb begin
    state_n  = state;
    score_n  = score_q;
    aliens_n = aliens_q;
    wave_n   = wave_q;
    ufo_n    = ufo_q;
    case (state)
      IDLE: begin
        score_n = '0;
        if (bus.start) begin
          state_n  = PLAY;
          aliens_n = NUM_ALIENS_C;
          ufo_n    = 1'b0;
        end
      end
      PLAY: begin
        score_n = (score_sum > SCORE_MAX) ? 11'd2047 : score_sum[10:0];
        if (ufo_ok) ufo_n = 1'b1;
        if (kill_ok) aliens_n = aliens_q - 6'd1;
        // Death wins over a simultaneous last kill; the kill still scores.
        if (bus.player_dead)                     state_n = LOST;
        else if (kill_ok && aliens_q == 6'd1)    state_n = WIN;
      end
      WIN: begin
        state_n = IDLE;
        score_n = '0;
        wave_n  = wave_q + 8'd1;
      end
      LOST: begin
        state_n = LOST;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      score_q  <= '0;
      aliens_q <= '0;
      wave_q   <= '0;
      ufo_q    <= 1'b0;
    end else begin
      score_q  <= score_n;
      aliens_q <= aliens_n;
      wave_q   <= wave_n;
      ufo_q    <= ufo_n;
    end
  end

  assign bus.wave_score  = score_q;
  assign bus.aliens_left = aliens_q;
  assign bus.wave_num    = wave_q;
  assign bus.win         = (state == WIN);
  assign bus.lose        = (state == LOST);

endmodule

// File: tb/tb_wave_scorer.sv
// Self-checking bench for wave_scorer: directed vector table plus multi-cycle sequences.
module tb_wave_scorer;

`ifdef UFO_BONUS_EN
  localparam int UFO_ADD = 110;
`else
  localparam int UFO_ADD = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wave_scorer_if bus();

  wave_scorer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       rst;
    logic       st;
    logic       k;
    logic [2:0] row;
    logic       u;
    logic       d;
    int         es;
    int         ea;
    logic       ew;
    logic       el;
    int         en;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input int es, input int ea, input logic ew,
                       input logic el, input int en);
    n_tests++;
    if (int'(bus.wave_score) != es || int'(bus.aliens_left) != ea || bus.win !== ew ||
        bus.lose !== el || int'(bus.wave_num) != en) begin
      n_fail++;
      $display("FAIL %s: got score=%0d aliens=%0d win=%0b lose=%0b wave=%0d, want score=%0d aliens=%0d win=%0b lose=%0b wave=%0d",
               name, bus.wave_score, bus.aliens_left, bus.win, bus.lose, bus.wave_num,
               es, ea, ew, el, en);
    end
  endtask

  // Hold the given inputs across one rising edge, then release them.
  task automatic apply(input logic r, input logic st, input logic k, input logic [2:0] row,
                       input logic u, input logic d);
    reset           = r;
    bus.start       = st;
    bus.kill        = k;
    bus.kill_row    = row;
    bus.ufo_kill    = u;
    bus.player_dead = d;
    @(posedge clk);
    #1;
    reset           = 1'b0;
    bus.start       = 1'b0;
    bus.kill        = 1'b0;
    bus.kill_row    = 3'd0;
    bus.ufo_kill    = 1'b0;
    bus.player_dead = 1'b0;
  endtask

  // Kills aliens by index in grid order: 11 per row, row = idx / 11.
  task automatic kills(input int first, input int count);
    for (int i = first; i < first + count; i++)
      apply(1'b0, 1'b0, 1'b1, 3'(i / 11), 1'b0, 1'b0);
  endtask

  initial begin
    //          rst   st    k     row   u     d     score        aliens win  lose wave
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 0,           55, 1'b0, 1'b0, 0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 30,          54, 1'b0, 1'b0, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 50,          53, 1'b0, 1'b0, 0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 60,          52, 1'b0, 1'b0, 0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 60,          52, 1'b0, 1'b0, 0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 60,          52, 1'b0, 1'b0, 0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 60,          52, 1'b0, 1'b0, 0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 60 + UFO_ADD, 52, 1'b0, 1'b0, 0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 60 + UFO_ADD, 52, 1'b0, 1'b0, 0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 80 + UFO_ADD, 51, 1'b0, 1'b0, 0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 80 + UFO_ADD, 51, 1'b0, 1'b1, 0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 80 + UFO_ADD, 51, 1'b0, 1'b1, 0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 80 + UFO_ADD, 51, 1'b0, 1'b1, 0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 0,           0,  1'b0, 1'b0, 0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 0,           0,  1'b0, 1'b0, 0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 0,           0,  1'b0, 1'b0, 0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 0,           55, 1'b0, 1'b0, 0};

    reset = 1'b1;
    bus.start = 1'b0; bus.kill = 1'b0; bus.kill_row = 3'd0;
    bus.ufo_kill = 1'b0; bus.player_dead = 1'b0;
    apply(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    check("reset", 0, 0, 1'b0, 1'b0, 0);

    for (int i = 0; i < 17; i++) begin
      apply(vecs[i].rst, vecs[i].st, vecs[i].k, vecs[i].row, vecs[i].u, vecs[i].d);
      check($sformatf("vec%0d", i), vecs[i].es, vecs[i].ea, vecs[i].ew, vecs[i].el, vecs[i].en);
    end

    // Full clear: wave is already started with 55 aliens.
    kills(0, 54);
    check("clear_54", 980, 1, 1'b0, 1'b0, 0);
    kills(54, 1);
    check("clear_win", 990, 0, 1'b1, 1'b0, 0);
    apply(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    check("clear_after", 0, 0, 1'b0, 1'b0, 1);
    apply(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    check("clear_restart", 0, 55, 1'b0, 1'b0, 1);

    // Last kill and death together: death wins, kill still scores.
    kills(0, 54);
    check("dead_54", 980, 1, 1'b0, 1'b0, 1);
    apply(1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1);
    check("dead_same", 990, 0, 1'b0, 1'b1, 1);
    apply(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    check("dead_start", 990, 0, 1'b0, 1'b1, 1);
    apply(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    check("dead_hold", 990, 0, 1'b0, 1'b1, 1);
    apply(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    check("dead_reset", 0, 0, 1'b0, 1'b0, 0);

    // Reset in the middle of a wave.
    apply(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    kills(0, 35);
    check("mid_20", 790, 20, 1'b0, 1'b0, 0);
    apply(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    check("mid_reset", 0, 0, 1'b0, 1'b0, 0);
    apply(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    check("mid_start", 0, 55, 1'b0, 1'b0, 0);

    // UFO with a kill in the same cycle, then a repeat UFO, then clear the wave.
    apply(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0);
    check("ufo_first", 30 + UFO_ADD, 54, 1'b0, 1'b0, 0);
    apply(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    check("ufo_second", 30 + UFO_ADD, 54, 1'b0, 1'b0, 0);
    kills(1, 53);
    check("ufo_54", 980 + UFO_ADD, 1, 1'b0, 1'b0, 0);
    kills(54, 1);
    check("ufo_win", 990 + UFO_ADD, 0, 1'b1, 1'b0, 0);
    apply(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    check("ufo_after", 0, 0, 1'b0, 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
